// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: iterative double-dabble binary-to-BCD converter with sign flag,
// leading-zero blanking (4'hF) and a start/busy/done handshake.
module bin_to_bcd_seq #(
  parameter int WIDTH     = 8,
  parameter int DIGITS    = 3,
  parameter int SIGNED_IN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [4*DIGITS-1:0] BCD_RST = {{(DIGITS-1){4'hF}}, 4'h0};
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0]    sr_q, sr_d, mag;
  logic [4*DIGITS-1:0] acc_q, acc_d, bcd_q, bcd_d, adj, blk;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic sign_q, sign_d, busy_q, busy_d, done_q, done_d, neg_q, neg_d, sgn, lead;
  assign sgn  = value[WIDTH-1] & (SIGNED_IN != 0);
  assign mag  = sgn ? -value : value;
  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign neg  = neg_q;
  always_comb begin
    adj  = acc_q;
    blk  = acc_q;
    lead = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i+:4] = (acc_q[4*i+:4] >= 4'd5) ? acc_q[4*i+:4] + 4'd3 : acc_q[4*i+:4];
    // Blank zeros from the top until the first nonzero digit; ones digit always shown
    for (int i = DIGITS - 1; i > 0; i--) begin
      lead = lead && (acc_q[4*i+:4] == 4'h0);
      blk[4*i+:4] = lead ? 4'hF : acc_q[4*i+:4];
    end
  end
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    case (state_q)
      IDLE: if (start) begin
        sr_d    = mag;
        sign_d  = sgn;
        acc_d   = '0;
        cnt_d   = '0;
        busy_d  = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        {acc_d, sr_d} = {adj, sr_q} << 1;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(WIDTH - 1)) ? FINISH : SHIFT;
      end
      FINISH: begin
        bcd_d   = blk;
        neg_d   = sign_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= BCD_RST;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
    end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed checks of signed/unsigned 8-bit and signed 12-bit converters.
module tb_bin_to_bcd_seq;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic st_a = 0, st_b = 0, st_c = 0;
  logic [7:0] v_a = 0, v_b = 0;
  logic [11:0] v_c = 0;
  logic busy_a, done_a, neg_a, busy_b, done_b, neg_b, busy_c, done_c, neg_c;
  logic [11:0] bcd_a, bcd_b;
  logic [15:0] bcd_c;
  int errs = 0, checks = 0, sel = 0;
  logic done_s, busy_s, neg_s;
  logic [15:0] bcd_s;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED_IN(1)) u_a (
    .clk(clk), .rst(rst), .start(st_a), .value(v_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .neg(neg_a));
  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED_IN(0)) u_b (
    .clk(clk), .rst(rst), .start(st_b), .value(v_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .neg(neg_b));
  bin_to_bcd_seq #(.WIDTH(12), .DIGITS(4), .SIGNED_IN(1)) u_c (
    .clk(clk), .rst(rst), .start(st_c), .value(v_c),
    .busy(busy_c), .done(done_c), .bcd(bcd_c), .neg(neg_c));

  always_comb begin
    done_s = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;
    busy_s = (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
    neg_s  = (sel == 0) ? neg_a  : (sel == 1) ? neg_b  : neg_c;
    bcd_s  = (sel == 0) ? {4'h0, bcd_a} : (sel == 1) ? {4'h0, bcd_b} : bcd_c;
  end

  task automatic set_in(input int u, input logic s, input logic [11:0] v);
    sel = u;
    case (u)
      0: begin st_a = s; v_a = v[7:0]; end
      1: begin st_b = s; v_b = v[7:0]; end
      default: begin st_c = s; v_c = v; end
    endcase
  endtask

  // Drives one start pulse and measures done latency, busy coverage and done width
  task automatic convert(input int u, input logic [11:0] v, output int lat,
                         output logic bok, output logic d2);
    @(negedge clk);
    set_in(u, 1'b1, v);
    @(negedge clk);
    set_in(u, 1'b0, v);
    lat = 0;
    bok = busy_s;
    while (!done_s && lat < 40) begin
      @(negedge clk);
      lat++;
      if (!done_s && !busy_s) bok = 1'b0;
    end
    if (busy_s) bok = 1'b0;
    @(negedge clk);
    d2 = done_s;
  endtask

  task automatic run(input string name, input int u, input logic [11:0] v,
                     input logic [15:0] eb, input logic en, input int el);
    int lat;
    logic bok, d2;
    convert(u, v, lat, bok, d2);
    checks++; if (lat !== el) begin errs++; $display("FAIL %s latency: got %0d want %0d", name, lat, el); end
    checks++; if (bok !== 1'b1) begin errs++; $display("FAIL %s busy window: got %b want 1", name, bok); end
    checks++; if (d2 !== 1'b0) begin errs++; $display("FAIL %s done width: got %b want 0", name, d2); end
    checks++; if (bcd_s !== eb) begin errs++; $display("FAIL %s bcd: got %h want %h", name, bcd_s, eb); end
    checks++; if (neg_s !== en) begin errs++; $display("FAIL %s neg: got %b want %b", name, neg_s, en); end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if ({bcd_a, bcd_b, bcd_c} !== {12'hFF0, 12'hFF0, 16'hFFF0}) begin
      errs++; $display("FAIL reset bcd: got %h %h %h want ff0 ff0 fff0", bcd_a, bcd_b, bcd_c); end
    checks++; if ({busy_a, done_a, neg_a, busy_b, done_b, neg_b, busy_c, done_c, neg_c} !== 9'b0) begin
      errs++; $display("FAIL reset flags: got %b want 0", {busy_a, done_a, neg_a, busy_b, done_b, neg_b, busy_c, done_c, neg_c}); end
    rst = 1'b0;
  endtask

  task automatic test_unsigned_values;
    run("zero", 0, 12'd0, 16'h0FF0, 1'b0, 9);
    run("127", 0, 12'd127, 16'h0127, 1'b0, 9);
    run("100", 0, 12'd100, 16'h0100, 1'b0, 9);
    run("u_251", 1, 12'hFB, 16'h0251, 1'b0, 9);
  endtask

  task automatic test_negative;
    run("m128", 0, 12'h80, 16'h0128, 1'b1, 9);
    run("m5", 0, 12'hFB, 16'h0FF5, 1'b1, 9);
    run("m1", 0, 12'hFF, 16'h0FF1, 1'b1, 9);
  endtask

  task automatic test_start_while_busy;
    int n = 0, nd = 0, first = -1;
    logic [15:0] b = '0;
    @(negedge clk); set_in(0, 1'b1, 12'd42);
    @(negedge clk); set_in(0, 1'b0, 12'd42);
    repeat (2) begin @(negedge clk); n++; end
    set_in(0, 1'b1, 12'd99);
    @(negedge clk); n++;
    set_in(0, 1'b0, 12'd99);
    if (done_s) begin nd++; first = n; b = bcd_s; end
    while (n < 25) begin
      @(negedge clk); n++;
      if (done_s) begin nd++; if (first < 0) begin first = n; b = bcd_s; end end
    end
    checks++; if (nd !== 1) begin errs++; $display("FAIL ignore_start done count: got %0d want 1", nd); end
    checks++; if (first !== 9) begin errs++; $display("FAIL ignore_start latency: got %0d want 9", first); end
    checks++; if (b !== 16'h0F42) begin errs++; $display("FAIL ignore_start bcd: got %h want 0f42", b); end
  endtask

  task automatic test_back_to_back;
    int n = 0, nd = 0, d1 = -1, d2 = -1;
    logic [15:0] b1 = '0, b2 = '0;
    @(negedge clk); set_in(0, 1'b1, 12'd9);
    @(negedge clk);
    while (n < 35) begin
      @(negedge clk); n++;
      if (done_s) begin
        nd++;
        if (nd == 1) begin d1 = n; b1 = bcd_s; end
        if (nd == 2) begin d2 = n; b2 = bcd_s; set_in(0, 1'b0, 12'd9); end
      end
    end
    checks++; if (nd !== 2) begin errs++; $display("FAIL b2b done count: got %0d want 2", nd); end
    checks++; if (d1 !== 9) begin errs++; $display("FAIL b2b first latency: got %0d want 9", d1); end
    checks++; if (d2 !== 19) begin errs++; $display("FAIL b2b second done: got %0d want 19", d2); end
    checks++; if ({b1, b2} !== {16'h0FF9, 16'h0FF9}) begin errs++; $display("FAIL b2b bcd: got %h %h want 0ff9 0ff9", b1, b2); end
    checks++; if (busy_s !== 1'b0) begin errs++; $display("FAIL b2b idle after: got busy=%b want 0", busy_s); end
  endtask

  task automatic test_mid_reset;
    int nd = 0;
    @(negedge clk); set_in(1, 1'b1, 12'd200);
    @(negedge clk); set_in(1, 1'b0, 12'd200);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bcd_b !== 12'hFF0) begin errs++; $display("FAIL midreset bcd: got %h want ff0", bcd_b); end
    checks++; if ({busy_b, done_b, neg_b} !== 3'b0) begin errs++; $display("FAIL midreset flags: got %b want 000", {busy_b, done_b, neg_b}); end
    @(negedge clk); rst = 1'b0;
    repeat (15) begin @(negedge clk); if (done_b) nd++; end
    checks++; if (nd !== 0) begin errs++; $display("FAIL midreset stray done: got %0d want 0", nd); end
    run("u_255", 1, 12'd255, 16'h0255, 1'b0, 9);
  endtask

  task automatic test_wide;
    run("w_m2048", 2, 12'h800, 16'h2048, 1'b1, 13);
    run("w_999", 2, 12'd999, 16'hF999, 1'b0, 13);
    run("w_2047", 2, 12'd2047, 16'h2047, 1'b0, 13);
  endtask

  initial begin
    test_reset;
    test_unsigned_values;
    test_negative;
    test_start_while_busy;
    test_back_to_back;
    test_mid_reset;
    test_wide;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter placed directly upstream of the per-digit seven-segment decoders. It takes a two's-complement calculator result and produces one 4-bit code per decimal digit, plus a sign flag, using an iterative shift-add-3 (double-dabble) datapath. Leading zeros are replaced with the blank code 4'hF, which the downstream decoder renders as all segments off. A start/busy/done handshake with the calculator core controls each conversion.

Parameters:
WIDTH, 8, bit width of the input value (two's complement when SIGNED_IN=1).
DIGITS, 3, number of BCD digit outputs. Must satisfy 10^DIGITS > 2^WIDTH.
SIGNED_IN, 1, 1 = input is two's complement; 0 = input is unsigned.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request a conversion. Sampled only in IDLE.
value  input  WIDTH  binary operand. Sampled only on the accepting edge.
busy  output  1  high from the accepting edge until the edge that asserts done.
done  output  1  one-cycle pulse when bcd and neg are updated.
bcd  output  4*DIGITS  digit codes. bcd[3:0] is the ones digit. Each digit is 0-9 or 4'hF (blank).
neg  output  1  high when the converted value was negative.

Behaviour:
- Reset (async, any state, including mid-conversion):
  - state=IDLE, busy=0, done=0, neg=0.
  - bcd = all digits 4'hF except bcd[3:0]=4'h0, so the display shows "0".
  - The internal shift register and counter are cleared, and any in-flight conversion is discarded.
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - If start=1 at edge k, capture the magnitude of value into the shift register (WIDTH bits; |-2^(WIDTH-1)| fits unsigned).
  - Capture sign = value[WIDTH-1] & SIGNED_IN, clear the BCD accumulator, set count=0, busy=1, and go to SHIFT.
  - If start=0, stay in IDLE.
- SHIFT, edges k+1 .. k+WIDTH:
  - Each edge first adds 3 to every accumulator digit >= 5, then shifts the {accumulator, shift register} pair left by 1 and increments count.
  - After the WIDTH-th shift (edge k+WIDTH), go to FINISH.
- FINISH, edge k+WIDTH+1:
  - Latch the accumulator into bcd with leading-zero blanking: scanning from the most significant digit, each zero digit becomes 4'hF until the first nonzero digit. Digit 0 is never blanked.
  - Set neg = captured sign, done=1, busy=0, and go to IDLE.
- Latency: done is high for exactly the cycle after edge k+WIDTH+1 (WIDTH+1 cycles after acceptance). done deasserts on the next edge unconditionally.
- bcd and neg hold their values between done pulses and change only on the FINISH edge or on reset.
- start while busy (SHIFT or FINISH) is ignored and not queued. Changes to value after acceptance have no effect.
- start high during the done cycle (state IDLE) is accepted, so back-to-back conversions run every WIDTH+2 cycles.
- SIGNED_IN=0: neg is always 0 and value is treated as unsigned.
- neg=1 implies a nonzero magnitude; negative zero cannot occur.

Test Plan:
1. value=8'd0, start pulse → busy for 9 cycles, done at cycle 9 after acceptance; bcd={F,F,0}, neg=0.
2. value=8'd127 → bcd={1,2,7}, neg=0. value=8'd100 → bcd={1,0,0}, showing internal zeros are not blanked.
3. value=8'h80 (-128) → bcd={1,2,8}, neg=1. value=8'hFB (-5) → bcd={F,F,5}, neg=1.
4. Accept value=42, then pulse start with value=99 three cycles later → the second start is ignored; a single done with bcd={F,4,2}. Separately, start held high through the done cycle with value=9 → a second conversion is accepted immediately; done again 9 cycles later with bcd={F,F,9}.
5. Assert rst at count=4 of a conversion of 8'd200 (SIGNED_IN=0 instance) → outputs go immediately to {F,F,0}, neg=0, busy=0, with no done. After release, a new start with 8'd255 → {2,5,5}.
6. WIDTH=12, DIGITS=4 instance: value=12'h800 (-2048) → bcd={2,0,4,8}, neg=1; done arrives 13 cycles after acceptance.
